// File: rtl/matrix_flat_printer_if.sv
// Bundle of the print-stage signals: the start/done control pair from the
// dimension-select print controller plus the single-byte UART handshake.
// Latency: n/a (wires only). Backpressure: carried by uart_tx_busy.
//
// Ports (as seen by the printer through the slave modport):
//   start, dim_m, dim_n, matrix_flat, use_crlf : job request and latched data
//   busy, done, error                          : job status
//   uart_tx_busy                               : UART transmitter busy
//   uart_tx_en, uart_tx_data                   : byte strobe and byte
interface matrix_flat_printer_if;
  logic         start;
  logic [2:0]   dim_m;
  logic [2:0]   dim_n;
  logic [199:0] matrix_flat;
  logic         use_crlf;
  logic         busy;
  logic         done;
  logic         error;
  logic         uart_tx_busy;
  logic         uart_tx_en;
  logic [7:0]   uart_tx_data;

  // Printer side.
  modport slave (
    input  start, dim_m, dim_n, matrix_flat, use_crlf, uart_tx_busy,
    output busy, done, error, uart_tx_en, uart_tx_data
  );

  // Controller + UART side.
  modport master (
    output start, dim_m, dim_n, matrix_flat, use_crlf, uart_tx_busy,
    input  busy, done, error, uart_tx_en, uart_tx_data
  );
endinterface

// File: rtl/matrix_flat_printer.sv
// Serialises a latched 5x5x8-bit matrix to the UART as rows of decimal ASCII.
// Latency: busy 1 cycle after start, error 2 cycles after start; each byte
//   waits for a full busy rise/fall of the UART before the next is issued.
// Backpressure: a byte is issued only when none is in flight and
//   uart_tx_busy is low; the block stalls indefinitely otherwise.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pif        : matrix_flat_printer_if.slave (start/dims/matrix/use_crlf in,
//                busy/done/error out, uart_tx_busy in, uart_tx_en/data out)
//
// Build option: define MATRIX_PRINTER_SIGNED_EN to treat elements as
// two's-complement signed values (negative values get a leading '-').
module matrix_flat_printer (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_flat_printer_if.slave  pif
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHECK = 4'd1,
    S_LOAD  = 4'd2,
    S_CONV  = 4'd3,
    S_EMIT  = 4'd4,
    S_SEP   = 4'd5,
    S_EOL   = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  state_t       state_q, state_d;

  // Job registers captured on start.
  logic [199:0] mat_q, mat_d;
  logic [2:0]   m_q, m_d;
  logic [2:0]   n_q, n_d;
  logic         crlf_q, crlf_d;

  // Position and conversion state.
  logic [2:0]   r_q, r_d;
  logic [2:0]   c_q, c_d;
  logic [7:0]   val_q, val_d;
  logic [1:0]   hund_q, hund_d;
  logic [3:0]   tens_q, tens_d;
  logic         neg_q, neg_d;
  // Sub-step inside EMIT (0 sign, 1 hundreds, 2 tens, 3 ones) and
  // inside EOL (0 CR, 1 LF).
  logic [1:0]   ph_q, ph_d;

  // UART handshake state.
  logic         inflight_q, inflight_d;
  logic         busy_prev_q, busy_prev_d;
  logic [7:0]   data_q, data_d;

  // Combinational helpers.
  logic [4:0]   k_w;
  logic [7:0]   elem_idx;
  logic [7:0]   elem_w;
  logic         elem_neg;
  logic [7:0]   elem_mag;
  logic         dims_bad;
  logic         last_col;
  logic         last_row;
  logic         want_send;
  logic [7:0]   tx_byte;
  logic         issue;
  logic         byte_done;
  logic         busy_w;
  logic         done_w;
  logic         error_w;
  logic [7:0]   tx_data_w;

  // Element k = r*dim_n + c, packed compact row-major, LSB first.
  assign k_w      = 5'(r_q) * 5'(n_q) + 5'(c_q);
  assign elem_idx = {k_w, 3'b000};
  assign elem_w   = mat_q[elem_idx +: 8];

`ifdef MATRIX_PRINTER_SIGNED_EN
  assign elem_neg = elem_w[7];
  // Magnitude of -128 is 128, which still fits unsigned 8 bits.
  assign elem_mag = elem_w[7] ? (~elem_w + 8'd1) : elem_w;
`else
  assign elem_neg = 1'b0;
  assign elem_mag = elem_w;
`endif

  assign dims_bad = (m_q == 3'd0) || (m_q > 3'd5) || (n_q == 3'd0) || (n_q > 3'd5);
  assign last_col = (c_q == 3'(n_q - 3'd1));
  assign last_row = (r_q == 3'(m_q - 3'd1));

  // A byte finishes on the UART's busy falling edge while we own one.
  assign byte_done = inflight_q && busy_prev_q && !pif.uart_tx_busy;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pif.start) state_d = S_CHECK;
      S_CHECK: state_d = dims_bad ? S_ERROR : S_LOAD;
      S_LOAD:  state_d = S_CONV;
      S_CONV:  if (val_q < 8'd10) state_d = S_EMIT;
      S_EMIT:  if (byte_done && (ph_q == 2'd3)) state_d = S_SEP;
      S_SEP: begin
        if (!want_send)     state_d = S_EOL;
        else if (byte_done) state_d = S_LOAD;
      end
      S_EOL:   if (byte_done && ph_q[0]) state_d = last_row ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs (byte selection, strobe, status pulses)
  // ------------------------------------------------------------------
  always_comb begin
    want_send = 1'b0;
    tx_byte   = 8'h00;
    case (state_q)
      S_EMIT: begin
        // Leading zeros are skipped: tens is printed if hundreds or tens
        // is non-zero; ones always.
        case (ph_q)
          2'd0: begin want_send = neg_q;                           tx_byte = 8'h2D; end
          2'd1: begin want_send = (hund_q != 2'd0);                tx_byte = 8'h30 + {6'd0, hund_q}; end
          2'd2: begin want_send = (hund_q != 2'd0) || (tens_q != 4'd0); tx_byte = 8'h30 + {4'd0, tens_q}; end
          default: begin want_send = 1'b1;                         tx_byte = 8'h30 + val_q; end
        endcase
      end
      S_SEP: begin
        want_send = !last_col;
        tx_byte   = 8'h20;
      end
      S_EOL: begin
        want_send = ph_q[0] || crlf_q;
        tx_byte   = ph_q[0] ? 8'h0A : 8'h0D;
      end
      default: begin
        want_send = 1'b0;
        tx_byte   = 8'h00;
      end
    endcase

    issue     = want_send && !inflight_q && !pif.uart_tx_busy;
    busy_w    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    done_w    = (state_q == S_DONE);
    error_w   = (state_q == S_ERROR);
    // Data is presented alongside the strobe and held afterwards.
    tx_data_w = issue ? tx_byte : data_q;
  end

  assign pif.busy         = busy_w;
  assign pif.done         = done_w;
  assign pif.error        = error_w;
  assign pif.uart_tx_en   = issue;
  assign pif.uart_tx_data = tx_data_w;

  // ------------------------------------------------------------------
  // Datapath next state
  // ------------------------------------------------------------------
  always_comb begin
    mat_d       = mat_q;
    m_d         = m_q;
    n_d         = n_q;
    crlf_d      = crlf_q;
    r_d         = r_q;
    c_d         = c_q;
    val_d       = val_q;
    hund_d      = hund_q;
    tens_d      = tens_q;
    neg_d       = neg_q;
    ph_d        = ph_q;
    inflight_d  = inflight_q;
    busy_prev_d = pif.uart_tx_busy;
    data_d      = data_q;

    if (issue) begin
      inflight_d = 1'b1;
      data_d     = tx_byte;
    end else if (byte_done) begin
      inflight_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pif.start) begin
          mat_d  = pif.matrix_flat;
          m_d    = pif.dim_m;
          n_d    = pif.dim_n;
          crlf_d = pif.use_crlf;
        end
      end
      S_CHECK: begin
        r_d = 3'd0;
        c_d = 3'd0;
      end
      S_LOAD: begin
        val_d  = elem_mag;
        neg_d  = elem_neg;
        hund_d = 2'd0;
        tens_d = 4'd0;
      end
      S_CONV: begin
        // Repeated subtraction: hundreds first, then tens.
        if (val_q >= 8'd100) begin
          val_d  = val_q - 8'd100;
          hund_d = hund_q + 2'd1;
        end else if (val_q >= 8'd10) begin
          val_d  = val_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          ph_d = 2'd0;
        end
      end
      S_EMIT: begin
        if (!want_send) begin
          ph_d = ph_q + 2'd1;
        end else if (byte_done && (ph_q != 2'd3)) begin
          ph_d = ph_q + 2'd1;
        end
      end
      S_SEP: begin
        if (!want_send) begin
          ph_d = 2'd0;
        end else if (byte_done) begin
          c_d = c_q + 3'd1;
        end
      end
      S_EOL: begin
        if (!want_send) begin
          ph_d = 2'd1;
        end else if (byte_done) begin
          if (!ph_q[0]) begin
            ph_d = 2'd1;
          end else if (!last_row) begin
            r_d = r_q + 3'd1;
            c_d = 3'd0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q       <= '0;
      m_q         <= 3'd0;
      n_q         <= 3'd0;
      crlf_q      <= 1'b0;
      r_q         <= 3'd0;
      c_q         <= 3'd0;
      val_q       <= 8'd0;
      hund_q      <= 2'd0;
      tens_q      <= 4'd0;
      neg_q       <= 1'b0;
      ph_q        <= 2'd0;
      inflight_q  <= 1'b0;
      busy_prev_q <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      mat_q       <= mat_d;
      m_q         <= m_d;
      n_q         <= n_d;
      crlf_q      <= crlf_d;
      r_q         <= r_d;
      c_q         <= c_d;
      val_q       <= val_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      neg_q       <= neg_d;
      ph_q        <= ph_d;
      inflight_q  <= inflight_d;
      busy_prev_q <= busy_prev_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_matrix_flat_printer.sv
// Scoreboard bench for matrix_flat_printer: a reference formatter pushes the
// expected byte stream, a monitor (which also models the UART) pops and
// compares on every strobe.
module tb_matrix_flat_printer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_flat_printer_if pif();

  matrix_flat_printer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int en_cnt   = 0;
  int hold_cycles = 1;
  int busy_cnt = 0;
  bit pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor + UART model. Busy rises the cycle after a strobe and stays
  // high for hold_cycles cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
        busy_cnt = 0;
        pif.uart_tx_busy = 1'b0;
      end else begin
        if (pif.done) done_cnt++;
        if (pif.error) err_cnt++;
        if (pif.done || pif.error)
          chk("pulse_exclusive", {30'd0, pif.done & pif.error, pif.uart_tx_en}, 32'd0);
        if (pif.uart_tx_en) begin
          en_cnt++;
          chk("strobe_while_busy", {31'd0, pif.uart_tx_busy}, 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h expected none", pif.uart_tx_data);
          end else begin
            chk("byte", {24'd0, pif.uart_tx_data}, {24'd0, exp_q.pop_front()});
          end
        end
        if (pending) begin
          pending = 1'b0;
          pif.uart_tx_busy = 1'b1;
          busy_cnt = hold_cycles;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) pif.uart_tx_busy = 1'b0;
        end
        if (pif.uart_tx_en) pending = 1'b1;
      end
    end
  end

  // Reference formatter: decimal text of each element, spaces between
  // columns, CR LF or LF after every row.
  task automatic push_expected(input int m, input int n, input logic [199:0] mat, input bit crlf);
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        int v;
        string s;
        v = int'(mat[(r*n + c)*8 +: 8]);
`ifdef MATRIX_PRINTER_SIGNED_EN
        if (v >= 128) begin
          exp_q.push_back(8'h2D);
          v = 256 - v;
        end
`endif
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        if (c < n - 1) exp_q.push_back(8'h20);
      end
      if (crlf) exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  function automatic logic [199:0] rand_mat();
    logic [199:0] mm;
    for (int k = 0; k < 25; k++) mm[k*8 +: 8] = 8'($urandom_range(0, 255));
    return mm;
  endfunction

  function automatic logic [199:0] fill_mat(input logic [7:0] v);
    logic [199:0] mm;
    for (int k = 0; k < 25; k++) mm[k*8 +: 8] = v;
    return mm;
  endfunction

  task automatic start_pulse(input int m, input int n, input logic [199:0] mat, input bit crlf);
    @(posedge clk);
    #1;
    pif.dim_m = 3'(m);
    pif.dim_n = 3'(n);
    pif.matrix_flat = mat;
    pif.use_crlf = crlf;
    pif.start = 1'b1;
    @(posedge clk);
    #1;
    pif.start = 1'b0;
  endtask

  task automatic run_job(input int m, input int n, input logic [199:0] mat, input bit crlf,
                         input int hold, input bit mid_restart, input bit start_on_done);
    bit legal;
    int d0, e0, b0, exp_len, cyc;
    legal = (m >= 1) && (m <= 5) && (n >= 1) && (n <= 5);
    hold_cycles = hold;
    exp_q.delete();
    if (legal) push_expected(m, n, mat, crlf);
    exp_len = exp_q.size();
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = en_cnt;
    start_pulse(m, n, mat, crlf);
    chk("busy_rise", {31'd0, pif.busy}, 32'd1);
    if (!legal) begin
      @(posedge clk);
      #1;
      chk("error_timing", {31'd0, pif.error}, 32'd1);
      @(posedge clk);
      #1;
    end else begin
      if (mid_restart) begin
        repeat (20) @(posedge clk);
        #1;
        pif.matrix_flat = ~mat;
        pif.dim_m = 3'd1;
        pif.use_crlf = ~crlf;
        pif.start = 1'b1;
        @(posedge clk);
        #1;
        pif.start = 1'b0;
      end
      cyc = 0;
      while (pif.done !== 1'b1 && cyc < 5000) begin
        @(negedge clk);
        cyc++;
      end
      if (pif.done !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
      end else if (start_on_done) begin
        pif.start = 1'b1;
        @(posedge clk);
        #1;
        pif.start = 1'b0;
        chk("start_on_done_ignored", {31'd0, pif.busy}, 32'd0);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bytes_left", exp_q.size(), 0);
    chk("byte_count", en_cnt - b0, exp_len);
    chk("done_count", done_cnt - d0, legal ? 1 : 0);
    chk("error_count", err_cnt - e0, legal ? 0 : 1);
    chk("busy_idle", {31'd0, pif.busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [199:0] mat;
    int b0, cyc;
    pif.start = 1'b0;
    pif.dim_m = 3'd0;
    pif.dim_n = 3'd0;
    pif.matrix_flat = '0;
    pif.use_crlf = 1'b0;
    pif.uart_tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, pif.busy}, 32'd0);
    chk("rst_done", {31'd0, pif.done}, 32'd0);
    chk("rst_error", {31'd0, pif.error}, 32'd0);
    chk("rst_en", {31'd0, pif.uart_tx_en}, 32'd0);
    chk("rst_data", {24'd0, pif.uart_tx_data}, 32'd0);
    rst_n = 1'b1;

    // 2x3 [1 2 3; 10 200 0], CR LF.
    mat = '0;
    mat[0*8 +: 8] = 8'd1;
    mat[1*8 +: 8] = 8'd2;
    mat[2*8 +: 8] = 8'd3;
    mat[3*8 +: 8] = 8'd10;
    mat[4*8 +: 8] = 8'd200;
    mat[5*8 +: 8] = 8'd0;
    run_job(2, 3, mat, 1'b1, 2, 1'b0, 1'b0);

    // 1x1 0xFF, LF only.
    mat = '0;
    mat[7:0] = 8'hFF;
    run_job(1, 1, mat, 1'b0, 1, 1'b0, 1'b0);

    // Signed extreme and boundary values in one row.
    mat = '0;
    mat[7:0]   = 8'h80;
    mat[15:8]  = 8'd100;
    mat[23:16] = 8'd99;
    mat[31:24] = 8'd9;
    mat[39:32] = 8'h7F;
    run_job(1, 5, mat, 1'b1, 1, 1'b0, 1'b0);

    // Illegal dimensions.
    run_job(0, 3, rand_mat(), 1'b1, 1, 1'b0, 1'b0);
    run_job(3, 6, rand_mat(), 1'b0, 1, 1'b0, 1'b0);

    // 5x5 of 7, slow UART.
    run_job(5, 5, fill_mat(8'd7), 1'b1, 10, 1'b0, 1'b0);

    // Restart and input change mid-job, then start on the done cycle.
    run_job(4, 4, rand_mat(), 1'b0, 3, 1'b1, 1'b1);

    // Reset during the second row.
    mat = '0;
    for (int k = 0; k < 9; k++) mat[k*8 +: 8] = 8'(k + 1);
    hold_cycles = 2;
    exp_q.delete();
    push_expected(3, 3, mat, 1'b0);
    b0 = en_cnt;
    start_pulse(3, 3, mat, 1'b0);
    cyc = 0;
    while ((en_cnt - b0) < 8 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    chk("reached_row1", ((en_cnt - b0) >= 8) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, pif.busy}, 32'd0);
    chk("midrst_done", {31'd0, pif.done}, 32'd0);
    chk("midrst_error", {31'd0, pif.error}, 32'd0);
    chk("midrst_en", {31'd0, pif.uart_tx_en}, 32'd0);
    chk("midrst_data", {24'd0, pif.uart_tx_data}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_job(3, 3, mat, 1'b0, 2, 1'b0, 1'b0);

    // Randomised jobs, mostly legal.
    for (int i = 0; i < 12; i++) begin
      int m, n;
      m = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      if (i == 5) m = 0;
      if (i == 9) n = 7;
      run_job(m, n, rand_mat(), 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_flat_printer.md
# matrix_flat_printer

Downstream print stage for the matrix display path. It accepts a latched 200-bit matrix image plus its dimensions and serialises it to the UART transmitter as rows of decimal ASCII text, one element at a time. Driven by the dimension-select print controller through a start/done pulse pair. Shares the single-byte UART handshake used across the print path.

## Interface
- No parameters. Matrix capacity is fixed at 5×5 elements of 8 bits each, 200 bits total.
- `clk` in 1 — system clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle request. Sampled only in IDLE.
- `dim_m` in 3 — row count. Legal range 1–5.
- `dim_n` in 3 — column count. Legal range 1–5.
- `matrix_flat` in 200 — element k at `[k*8 +: 8]`, where k = r*dim_n + c. Packing is row-major, compact, LSB-first.
- `use_crlf` in 1 — 1: row terminator is CR LF. 0: row terminator is LF only.
- `busy` out 1 — high from the cycle after an accepted start until DONE or ERROR.
- `done` out 1 — one-cycle pulse after the final terminator byte completes.
- `error` out 1 — one-cycle pulse on illegal dimensions. No bytes are sent in this case.
- `uart_tx_busy` in 1 — UART transmitter busy.
- `uart_tx_en` out 1 — one-cycle send strobe.
- `uart_tx_data` out 8 — byte to send. Valid on the strobe cycle and held until the next strobe.

## Operation
- Latch on start:
  - `matrix_flat`, `dim_m`, `dim_n` and `use_crlf` are captured when start is accepted.
  - Later changes to these inputs have no effect on the job in progress.
- States:
  - IDLE → CHECK on start.
  - CHECK → ERROR if either dimension is 0 or greater than 5. Otherwise CHECK → LOAD with r=c=0.
  - LOAD: fetch element k into the conversion register and clear the hundreds, tens and ones counters.
  - CONV: one subtraction per cycle.
    - While value ≥ 100, subtract 100 and increment hundreds.
    - Then, while value ≥ 10, subtract 10 and increment tens.
    - The remainder is ones.
    - Worst case is 2+5 = 7 cycles, for value 255.
  - EMIT: send digits with leading zeros suppressed. The ones digit is always sent.
  - SEP: send space (0x20) if c < dim_n−1, then c++ and go to LOAD. Otherwise go to EOL.
  - EOL: send CR (0x0D) if use_crlf, then LF (0x0A).
    - If r < dim_m−1: r++, c=0, go to LOAD.
    - Otherwise go to DONE.
  - DONE: pulse done, → IDLE.
  - ERROR: pulse error, → IDLE.
- Output format:
  - No trailing space on any row.
  - The last row is also terminated.
  - No header or blank line is emitted.
- Byte handshake (every byte):
  - Issue a byte when no byte is in flight and `uart_tx_busy`=0: drive `uart_tx_data`, pulse `uart_tx_en`, mark the byte in flight.
  - A byte completes on a falling edge of `uart_tx_busy` (registered previous value 1, current 0).
  - Then clear the in-flight flag and advance.
  - If the UART never asserts busy, the block waits indefinitely. This is by design.
- Width rules:
  - Index k = r*dim_n + c, 5 bits wide, maximum 24.
  - Digit byte = 0x30 + digit.
  - Counters: hundreds 2 bits, tens 4 bits.

## Timing
- Reset values: busy=0, done=0, error=0, uart_tx_en=0, uart_tx_data=0x00. State is IDLE and all counters are 0.
- Cycle timing:
  - busy rises 1 cycle after the start cycle.
  - error pulses 2 cycles after start.
  - The first `uart_tx_en` is no earlier than 3 cycles after start plus the CONV cycles.
- Start handling:
  - A start while busy is ignored and not queued.
  - A start on the same cycle as the done pulse is ignored.
  - Start is next accepted the cycle after the block returns to IDLE.
- Reset mid-operation:
  - Immediately IDLE and all outputs return to reset values.
  - A partially sent byte is abandoned.
  - No done or error pulse is produced.
- `done` and `error` are never high together. Neither is asserted in the same cycle as `uart_tx_en`.

## Configuration
- `MATRIX_PRINTER_SIGNED_EN` defined:
  - Elements are two's-complement signed, range −128..127.
  - Negative values emit `-` (0x2D) and then the magnitude digits. For example, 0x80 prints `-128`.
- Undefined: elements are unsigned 0..255 and `-` is never emitted.

## Test plan
- 2×3 matrix [1 2 3; 10 200 0], use_crlf=1 → byte stream `1 2 3\r\n10 200 0\r\n` (17 bytes), then one done pulse. error is never asserted.
- 1×1 matrix, value 0xFF, use_crlf=0:
  - Unsigned build → `255\n`.
  - Signed build → `-1\n`.
- dim_m=0, dim_n=3 → error pulse 2 cycles after start. uart_tx_en is never asserted, busy returns to 0, done is never asserted.
- 5×5 matrix of all 7, UART busy held 10 cycles per byte → 25 `7` digits with 4 spaces per row and 5 CR LF pairs. No strobe is issued while uart_tx_busy=1.
- Second start pulsed mid-job, with matrix_flat changed after start → stream matches the originally latched data, and exactly one done pulse.
- rst_n asserted during the second row → outputs at reset values immediately. A fresh start afterwards prints the full matrix from row 0.
